// File: rtl/mo_linebuf_writer.sv
// Motion-object line-buffer writer.
// Takes the two picture-ROM words of a matched object row, serialises them
// into 8 pixels and writes the opaque ones into the line buffer at the
// object's horizontal position, mirrored when cocktail flip is active.
module mo_linebuf_writer #(
    parameter int PIX_BITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  ce,
    input  logic                  start,
    input  logic                  matchn,
    input  logic                  flip,
    input  logic [7:0]            hpos,
    input  logic [4*PIX_BITS-1:0] pic_data,
    output logic                  wsel,
    output logic                  lb_we,
    output logic [7:0]            lb_addr,
    output logic [PIX_BITS-1:0]   lb_data,
    output logic                  busy,
    output logic                  done
);

    localparam int WORD_W = 4 * PIX_BITS;

    typedef enum logic [2:0] {
        IDLE,
        LOAD0,
        SHIFT0,
        LOAD1,
        SHIFT1,
        DONE
    } state_t;

    state_t              state;
    logic [WORD_W-1:0]   shreg;
    logic [1:0]          cnt;
    logic [7:0]          xpos;
    logic                flip_q;
    logic [PIX_BITS-1:0] pix;

    // Flipped objects drain the word from the low nibble, normal ones from the high nibble.
    assign pix = flip_q ? shreg[PIX_BITS-1:0] : shreg[WORD_W-1 -: PIX_BITS];

    // Slot sequencer: fetch two words, emit four pixels from each, then pulse done.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            wsel    <= 1'b0;
            lb_we   <= 1'b0;
            lb_addr <= '0;
            lb_data <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            shreg   <= '0;
            cnt     <= '0;
            xpos    <= '0;
            flip_q  <= 1'b0;
        end else if (ce) begin
            case (state)
                IDLE: begin
                    lb_we <= 1'b0;
                    done  <= 1'b0;
                    if (start) begin
                        if (!matchn) begin
                            state  <= LOAD0;
                            busy   <= 1'b1;
                            flip_q <= flip;
                            xpos   <= flip ? hpos + 8'd7 : hpos;
                            wsel   <= flip;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                LOAD0: begin
                    shreg <= pic_data;
                    cnt   <= '0;
                    wsel  <= ~wsel;
                    lb_we <= 1'b0;
                    state <= SHIFT0;
                end
                SHIFT0, SHIFT1: begin
                    lb_we   <= (pix != '0);
                    lb_addr <= xpos;
                    lb_data <= pix;
                    shreg   <= flip_q ? (shreg >> PIX_BITS) : (shreg << PIX_BITS);
                    xpos    <= flip_q ? xpos - 8'd1 : xpos + 8'd1;
                    cnt     <= cnt + 2'd1;
                    if (cnt == 2'd3) begin
                        state <= (state == SHIFT0) ? LOAD1 : DONE;
                    end
                end
                LOAD1: begin
                    shreg <= pic_data;
                    cnt   <= '0;
                    lb_we <= 1'b0;
                    state <= SHIFT1;
                end
                DONE: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    wsel  <= 1'b0;
                    lb_we <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mo_linebuf_writer.sv
// Self-checking bench for mo_linebuf_writer: a picture-ROM model answers
// wsel, and every slot is compared tick by tick against a reference model
// that places the object's 8 pixels straight from the ROM words.
module tb_mo_linebuf_writer;

    localparam int PIX_BITS = 4;
    localparam int WW       = 4 * PIX_BITS;
    localparam int OW       = 12 + PIX_BITS;
    localparam int NT       = 13;

    logic                clk = 1'b0;
    logic                reset;
    logic                ce;
    logic                start;
    logic                matchn;
    logic                flip;
    logic [7:0]          hpos;
    logic [WW-1:0]       pic_data;
    logic                wsel;
    logic                lb_we;
    logic [7:0]          lb_addr;
    logic [PIX_BITS-1:0] lb_data;
    logic                busy;
    logic                done;

    logic [WW-1:0] rom_w0;
    logic [WW-1:0] rom_w1;

    int n_checks = 0;
    int n_pass   = 0;
    int frozen_bad;

    logic [OW-1:0] obs_vec  [NT];
    logic [OW-1:0] exp_vec  [NT];
    logic [OW-1:0] exp_mask [NT];

    mo_linebuf_writer #(.PIX_BITS(PIX_BITS)) dut (
        .clk      (clk),
        .reset    (reset),
        .ce       (ce),
        .start    (start),
        .matchn   (matchn),
        .flip     (flip),
        .hpos     (hpos),
        .pic_data (pic_data),
        .wsel     (wsel),
        .lb_we    (lb_we),
        .lb_addr  (lb_addr),
        .lb_data  (lb_data),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    // Picture ROM: the two words of the matched row, selected by wsel.
    assign pic_data = wsel ? rom_w1 : rom_w0;

    function automatic logic [OW-1:0] snap();
        return {wsel, busy, done, lb_we, lb_addr, lb_data};
    endfunction

    // Reference: pixel k (0..7) is nibble k of word0:word1, MSB first, and it
    // lands at hpos+k; flip emits the same pixels in reverse order.
    task automatic build_expected(input logic [7:0] h, input logic f, input logic mn,
                                  input logic [WW-1:0] w0, input logic [WW-1:0] w1);
        logic [PIX_BITS-1:0] p [8];
        logic [WW-1:0]       w;
        logic                e_wsel, e_busy, e_done, e_we;
        logic [7:0]          e_addr;
        logic [PIX_BITS-1:0] e_data;
        int                  i;
        int                  idx;
        for (int k = 0; k < 8; k++) begin
            w    = (k < 4) ? w0 : w1;
            p[k] = w[(3 - (k % 4)) * PIX_BITS +: PIX_BITS];
        end
        for (int k = 0; k < NT; k++) begin
            exp_mask[k] = {4'b1111, {(8 + PIX_BITS){1'b0}}};
            if (mn) begin
                exp_vec[k] = {1'b0, 1'b0, (k == 1), 1'b0, 8'h00, {PIX_BITS{1'b0}}};
            end else begin
                e_wsel = (k == 0) ? f : ((k <= 10) ? ~f : 1'b0);
                e_busy = (k <= 10);
                e_done = (k == 11);
                e_we   = 1'b0;
                e_addr = 8'h00;
                e_data = '0;
                if (k >= 2 && k <= 5)      i = k - 2;
                else if (k >= 7 && k <= 10) i = k - 3;
                else                        i = -1;
                if (i >= 0) begin
                    idx         = f ? 7 - i : i;
                    e_data      = p[idx];
                    e_addr      = h + 8'(idx);
                    e_we        = (p[idx] != '0);
                    exp_mask[k] = '1;
                end
                exp_vec[k] = {e_wsel, e_busy, e_done, e_we, e_addr, e_data};
            end
        end
    endtask

    // Drives one slot and records outputs after each of the ticks T..T+12.
    task automatic run_slot(input logic [7:0] h, input logic f, input logic mn,
                            input logic [WW-1:0] w0, input logic [WW-1:0] w1,
                            input int dup_k, input int gap_k);
        rom_w0 = w0;
        rom_w1 = w1;
        hpos   = h;
        flip   = f;
        matchn = mn;
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        hpos   = 8'($urandom);
        flip   = 1'($urandom);
        matchn = 1'($urandom);
        obs_vec[0] = snap();
        frozen_bad = 0;
        for (int k = 1; k < NT; k++) begin
            if (k == gap_k) begin
                ce = 1'b0;
                repeat (3) begin
                    @(negedge clk);
                    if (snap() !== obs_vec[k-1]) frozen_bad++;
                end
                ce = 1'b1;
            end
            start = (k == dup_k);
            @(negedge clk);
            start = 1'b0;
            obs_vec[k] = snap();
        end
    endtask

    function automatic logic [WW-1:0] rand_word();
        logic [WW-1:0] w;
        for (int j = 0; j < 4; j++) begin
            w[j*PIX_BITS +: PIX_BITS] = ($urandom_range(0, 3) == 0) ? '0 : PIX_BITS'($urandom);
        end
        return w;
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (snap() !== '0) $display("[TB] FAIL reset_values: got %h expected %h", snap(), {OW{1'b0}});
        else n_pass++;
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if (snap() !== '0) $display("[TB] FAIL idle_after_reset: got %h expected %h", snap(), {OW{1'b0}});
        else n_pass++;
    endtask

    task automatic test_patterns();
        logic [7:0]    th [3] = '{8'h10, 8'h10, 8'hFC};
        logic          tf [3] = '{1'b0, 1'b1, 1'b0};
        logic [WW-1:0] t0 [3] = '{16'h1234, 16'h1234, 16'h0A0B};
        logic [WW-1:0] t1 [3] = '{16'h5678, 16'h5678, 16'h0C0D};
        for (int n = 0; n < 3; n++) begin
            build_expected(th[n], tf[n], 1'b0, t0[n], t1[n]);
            run_slot(th[n], tf[n], 1'b0, t0[n], t1[n], -1, -1);
            for (int k = 0; k < NT; k++) begin
                n_checks++;
                if ((obs_vec[k] & exp_mask[k]) !== exp_vec[k])
                    $display("[TB] FAIL pattern%0d T+%0d: got %h expected %h", n, k, obs_vec[k] & exp_mask[k], exp_vec[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_nomatch();
        build_expected(8'h10, 1'b0, 1'b1, 16'h1234, 16'h5678);
        run_slot(8'h10, 1'b0, 1'b1, 16'h1234, 16'h5678, -1, -1);
        for (int k = 0; k < NT; k++) begin
            n_checks++;
            if ((obs_vec[k] & exp_mask[k]) !== exp_vec[k])
                $display("[TB] FAIL nomatch T+%0d: got %h expected %h", k, obs_vec[k] & exp_mask[k], exp_vec[k]);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back_start_and_ce();
        logic [7:0]    h  = 8'($urandom);
        logic          f  = 1'($urandom);
        logic [WW-1:0] w0 = rand_word();
        logic [WW-1:0] w1 = rand_word();
        int            active;
        build_expected(h, f, 1'b0, w0, w1);
        run_slot(h, f, 1'b0, w0, w1, 3, 8);
        for (int k = 0; k < NT; k++) begin
            n_checks++;
            if ((obs_vec[k] & exp_mask[k]) !== exp_vec[k])
                $display("[TB] FAIL start_ce T+%0d: got %h expected %h", k, obs_vec[k] & exp_mask[k], exp_vec[k]);
            else n_pass++;
        end
        n_checks++;
        if (frozen_bad !== 0) $display("[TB] FAIL ce_freeze: got %0d changes expected 0", frozen_bad);
        else n_pass++;
        active = 0;
        repeat (3) begin
            @(negedge clk);
            if (busy || lb_we || done) active++;
        end
        n_checks++;
        if (active !== 0) $display("[TB] FAIL ignored_start: got %0d active ticks expected 0", active);
        else n_pass++;
    endtask

    task automatic test_random();
        logic [7:0]    h;
        logic          f;
        logic          mn;
        logic [WW-1:0] w0;
        logic [WW-1:0] w1;
        for (int n = 0; n < 16; n++) begin
            h  = 8'($urandom);
            f  = 1'($urandom);
            mn = ($urandom_range(0, 3) == 0);
            w0 = rand_word();
            w1 = rand_word();
            build_expected(h, f, mn, w0, w1);
            run_slot(h, f, mn, w0, w1, -1, -1);
            for (int k = 0; k < NT; k++) begin
                n_checks++;
                if ((obs_vec[k] & exp_mask[k]) !== exp_vec[k])
                    $display("[TB] FAIL random%0d T+%0d: got %h expected %h", n, k, obs_vec[k] & exp_mask[k], exp_vec[k]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int active;
        rom_w0 = 16'h1234;
        rom_w1 = 16'h5678;
        hpos   = 8'h40;
        flip   = 1'b0;
        matchn = 1'b0;
        start  = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        #1;
        n_checks++;
        if (snap() !== '0) $display("[TB] FAIL async_reset: got %h expected %h", snap(), {OW{1'b0}});
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        active = 0;
        repeat (14) begin
            @(negedge clk);
            if (busy || lb_we || done) active++;
        end
        n_checks++;
        if (active !== 0) $display("[TB] FAIL post_reset_idle: got %0d active ticks expected 0", active);
        else n_pass++;
        build_expected(8'h40, 1'b1, 1'b0, 16'h9ABC, 16'hDE0F);
        run_slot(8'h40, 1'b1, 1'b0, 16'h9ABC, 16'hDE0F, -1, -1);
        for (int k = 0; k < NT; k++) begin
            n_checks++;
            if ((obs_vec[k] & exp_mask[k]) !== exp_vec[k])
                $display("[TB] FAIL after_reset T+%0d: got %h expected %h", k, obs_vec[k] & exp_mask[k], exp_vec[k]);
            else n_pass++;
        end
    endtask

    // Runs each scenario in turn and prints the summary.
    initial begin
        reset  = 1'b1;
        ce     = 1'b1;
        start  = 1'b0;
        matchn = 1'b1;
        flip   = 1'b0;
        hpos   = 8'h00;
        rom_w0 = '0;
        rom_w1 = '0;
        test_reset();
        test_patterns();
        test_nomatch();
        test_back_to_back_start_and_ce();
        test_random();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/mo_linebuf_writer.md
Name: mo_linebuf_writer

Overview:
- Consumer end of the motion-object vertical match path.
- Once per object slot it takes the row-match flag and the two picture-ROM words for the matched row (word select via the ROM address LSB).
- It serialises them into 8 pixels and writes the opaque ones into the motion-object line buffer at the object's horizontal position, honouring cocktail flip.
- It sits between the picture ROM and the line-buffer RAM and is paced by the pixel clock enable.

Parameters:
- PIX_BITS, 4, bits per pixel. The ROM word is 4*PIX_BITS wide and holds 4 pixels, MSB nibble first.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- ce  in  1  pixel clock enable; all state advances only on clk edges with ce=1 ("tick")
- start  in  1  object-slot strobe, sampled on a tick
- matchn  in  1  active-low row match for the current slot, sampled with start
- flip  in  1  cocktail flip (PLAYER2), sampled with start
- hpos  in  8  object horizontal position, sampled with start
- pic_data  in  4*PIX_BITS  picture ROM word for the currently driven wsel
- wsel  out  1  ROM word select (address LSB); 0 = first word fetched
- lb_we  out  1  line-buffer write enable; the consumer qualifies it with ce
- lb_addr  out  8  line-buffer address
- lb_data  out  PIX_BITS  pixel value
- busy  out  1  high from start acceptance until done
- done  out  1  one-tick pulse at end of slot

Behaviour:
- Reset values (async): state IDLE, wsel=0, lb_we=0, lb_addr=0, lb_data=0, busy=0, done=0, shift register and counter cleared.
- Reset asserted mid-operation aborts immediately. No further writes occur; the next slot needs a new start.
- All outputs are registered and change only on ticks.
- States:
  - IDLE: start & ~matchn -> LOAD0. busy<=1. Latch hpos, flip. wsel<=flip (flip fetches the second word first).
  - IDLE: start & matchn -> DONE (no fetch, no writes).
  - IDLE: start=0 -> remain in IDLE.
  - LOAD0: capture pic_data into shift reg, cnt<=0, wsel<=~wsel -> SHIFT0.
  - SHIFT0: each tick emits one pixel; after 4 pixels -> LOAD1.
  - LOAD1: capture pic_data, cnt<=0 -> SHIFT1. lb_we=0 in LOAD states.
  - SHIFT1: emits 4 pixels -> DONE.
  - DONE: done=1, busy=0, wsel<=0 -> IDLE.
- Timing: start accepted at tick T. Pixels appear at T+2..T+5 and T+7..T+10, done at T+11. Total 12 ticks. A non-matching slot gives done at T+1.
- Pixel emission:
  - Non-flipped: pixel order is MSB nibble first; pixel index i = 0..7 goes to lb_addr = hpos + i.
  - Flipped: nibbles are emitted LSB first and lb_addr = hpos + 7 - i, so the object is mirrored.
  - Addition is modulo 256. An object at hpos >= 249 wraps to addresses 0..
- Transparency: pixel value 0 gives lb_we=0 for that tick. lb_addr and lb_data still update.
- start while busy (any state other than IDLE) is ignored. matchn, flip and hpos changes after acceptance have no effect.
- pic_data must be valid on the tick following a wsel change. The block samples it only in LOAD0/LOAD1.

Test Plan:
1. reset, start=1 matchn=0 flip=0 hpos=0x10, word0=0x1234, word1=0x5678 -> writes (0x10,1),(0x11,2),(0x12,3),(0x13,4), then (0x14..0x17 = 5,6,7,8). wsel 0 then 1. done at T+11.
2. Same stimulus with flip=1 (word order swapped: wsel=1 first, returns 0x5678) -> writes (0x17,8),(0x16,7),(0x15,6),(0x14,5),(0x13,4)..(0x10,1).
3. start with matchn=1 -> no lb_we for the whole slot, done at T+1, busy never high beyond T.
4. hpos=0xFC, words 0x0A0B/0x0C0D -> writes only at 0xFD(A), 0xFF(B), 0x01(C), 0x03(D). Zero pixels give lb_we=0 and addresses wrap.
5. Second start pulses during SHIFT0, and ce held low for 3 clocks mid-SHIFT1 -> second start ignored. Outputs frozen while ce=0. The sequence resumes identically.
6. reset asserted at tick T+6 -> all outputs 0 asynchronously. After release: IDLE, no writes until the next accepted start.
